// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, pointer width and Gray/binary conversion helpers.
// Latency: none (package only; functions are pure combinational).
// Backpressure: not applicable.
package fifo_pkg;

   localparam int ADDR_BITS_DFLT  = 3;
   localparam int FIFO_DEPTH_DFLT = 1 << ADDR_BITS_DFLT;
   // Pointers carry one extra MSB beyond the address so full and empty can be told apart.
   localparam int PTR_BITS_DFLT   = ADDR_BITS_DFLT + 1;

   // The helpers work on a fixed wide vector; callers zero-extend in and truncate out,
   // which is exact for both conversions because the unused upper bits stay zero.
   localparam int PTR_MAX_W = 32;
   typedef logic [PTR_MAX_W-1:0] ptr_max_t;

   function automatic ptr_max_t bin2gray(input ptr_max_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_max_t gray2bin(input ptr_max_t g);
      ptr_max_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-flop synchronizer for a Gray-coded bus crossing into the local clock domain.
// Latency: STAGES clock edges from a stable input to q_o.
// Backpressure: none; free-running, captures every edge.
module bus_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   // Stage 0 is the first (metastability-exposed) flop; stage STAGES-1 feeds the output.
   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [STAGES-1:0][WIDTH-1:0] sync_d;

   // Shift the captured bus one stage deeper each edge.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
   end

   // Synchronizer flops, cleared asynchronously so both domains restart from pointer 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO: read pointer, write-pointer sync, empty/almost-empty/level.
// Latency: pop effects visible after the accepting edge; writes visible SYNC_STAGES edges after arrival.
// Backpressure: RINC is ignored while R_EMPTY=1; one pop per cycle otherwise.
module fifo_read_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDRESS_BITS    = ADDR_BITS_DFLT,
   parameter int FIFO_DEPTH      = FIFO_DEPTH_DFLT,
   parameter int SYNC_STAGES     = 2,
   parameter int ALMOST_EMPTY_TH = 1
) (
   input  logic                    R_CLK,
   input  logic                    R_RST,
   input  logic                    RINC,
   input  logic [ADDRESS_BITS:0]   WQ_PTR_GRAY,
   output logic [ADDRESS_BITS-1:0] R_ADDRESS,
   output logic [ADDRESS_BITS:0]   RQ_PTR_GRAY,
   output logic                    R_EMPTY,
   output logic                    R_ALMOST_EMPTY,
   output logic [ADDRESS_BITS:0]   R_LEVEL,
   output logic                    R_POP
);

   localparam int PW = ADDRESS_BITS + 1;
   localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

   // Elaboration-time guards on the geometry this block relies on.
   if (FIFO_DEPTH != (1 << ADDRESS_BITS)) begin : g_bad_depth
      $error("fifo_read_ctrl: FIFO_DEPTH must equal 2**ADDRESS_BITS");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("fifo_read_ctrl: SYNC_STAGES must be at least 2");
   end

   logic [PW-1:0] rbin_q,  rbin_d;
   logic [PW-1:0] rgray_q, rgray_d;
   logic [PW-1:0] level_q, level_d;
   logic          empty_q, empty_d;
   logic          aempty_q, aempty_d;

   logic [PW-1:0] wq_sync_gray;
   logic [PW-1:0] wq_sync_bin;

   // Only the Gray write pointer crosses; it is converted to binary after synchronization.
   bus_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_wptr_sync (
      .clk_i (R_CLK),
      .rst_i (R_RST),
      .d_i   (WQ_PTR_GRAY),
      .q_o   (wq_sync_gray)
   );

   assign wq_sync_bin = PW'(gray2bin(PTR_MAX_W'(wq_sync_gray)));

   // A pop is accepted only against the registered empty flag, so no over-read is possible.
   assign R_POP = RINC & ~empty_q;

   // Next pointer and status, all computed against the post-pop pointer so the flags
   // update on the same edge that consumes an entry.
   always_comb begin
      rbin_d   = rbin_q + PW'(R_POP);
      rgray_d  = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
      level_d  = wq_sync_bin - rbin_d;
      empty_d  = (rgray_d == wq_sync_gray);
      aempty_d = (level_d <= AE_TH);
   end

   // Pointer and status registers; reset leaves the FIFO empty with both pointers at 0.
   always_ff @(posedge R_CLK or posedge R_RST) begin
      if (R_RST) begin
         rbin_q   <= '0;
         rgray_q  <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
      end else begin
         rbin_q   <= rbin_d;
         rgray_q  <= rgray_d;
         level_q  <= level_d;
         empty_q  <= empty_d;
         aempty_q <= aempty_d;
      end
   end

   // Memory address comes straight from the binary pointer register.
   assign R_ADDRESS      = rbin_q[ADDRESS_BITS-1:0];
   assign RQ_PTR_GRAY    = rgray_q;
   assign R_LEVEL        = level_q;
   assign R_EMPTY        = empty_q;
   assign R_ALMOST_EMPTY = aempty_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: scoreboard of expected post-edge outputs, checked on the falling edge.
// Latency: one expected record per clock cycle driven.
// Backpressure: not applicable.
module tb_fifo_read_ctrl;

   logic       R_CLK = 1'b0;
   logic       R_RST;
   logic       RINC;
   logic [3:0] WQ_PTR_GRAY;
   logic [2:0] R_ADDRESS;
   logic [3:0] RQ_PTR_GRAY;
   logic       R_EMPTY;
   logic       R_ALMOST_EMPTY;
   logic [3:0] R_LEVEL;
   logic       R_POP;

   fifo_read_ctrl #(
      .ADDRESS_BITS    (3),
      .FIFO_DEPTH      (8),
      .SYNC_STAGES     (2),
      .ALMOST_EMPTY_TH (1)
   ) dut (
      .R_CLK          (R_CLK),
      .R_RST          (R_RST),
      .RINC           (RINC),
      .WQ_PTR_GRAY    (WQ_PTR_GRAY),
      .R_ADDRESS      (R_ADDRESS),
      .RQ_PTR_GRAY    (RQ_PTR_GRAY),
      .R_EMPTY        (R_EMPTY),
      .R_ALMOST_EMPTY (R_ALMOST_EMPTY),
      .R_LEVEL        (R_LEVEL),
      .R_POP          (R_POP)
   );

   always #5 R_CLK = ~R_CLK;

   typedef struct {
      logic [2:0] addr;
      logic [3:0] gray;
      logic [3:0] level;
      logic       empty;
      logic       aempty;
   } exp_t;

   exp_t  exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   string phase = "init";

   function automatic exp_t mk(input int a, input int g, input int l, input int e, input int ae);
      exp_t r;
      r.addr   = 3'(a);
      r.gray   = 4'(g);
      r.level  = 4'(l);
      r.empty  = 1'(e);
      r.aempty = 1'(ae);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, expv);
      end
   endtask

   task automatic sb_check();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s/sb_underflow: observed no expected record", phase);
         return;
      end
      e = exp_q.pop_front();
      chk("addr",   32'(R_ADDRESS),      32'(e.addr));
      chk("gray",   32'(RQ_PTR_GRAY),    32'(e.gray));
      chk("level",  32'(R_LEVEL),        32'(e.level));
      chk("empty",  32'(R_EMPTY),        32'(e.empty));
      chk("aempty", 32'(R_ALMOST_EMPTY), 32'(e.aempty));
   endtask

   // Called on a falling edge: drive, check the combinational pop, push expectation,
   // let one rising edge happen, then compare on the next falling edge.
   task automatic cyc(input logic rinc, input logic [3:0] wq, input logic pop_e, input exp_t e);
      RINC        = rinc;
      WQ_PTR_GRAY = wq;
      #1;
      chk("pop", 32'(R_POP), 32'(pop_e));
      exp_q.push_back(e);
      @(posedge R_CLK);
      @(negedge R_CLK);
      sb_check();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gtab[9];
      int wg1[4];
      int wg2[4];
      int wa2[4];
      gtab = '{0, 1, 3, 2, 6, 7, 5, 4, 12};
      wg1  = '{13, 15, 14, 10};
      wg2  = '{11, 9, 8, 0};
      wa2  = '{5, 6, 7, 0};

      // Reset state
      phase       = "reset";
      R_RST       = 1'b1;
      RINC        = 1'b0;
      WQ_PTR_GRAY = 4'd0;
      #3;
      chk("addr",   32'(R_ADDRESS),      32'd0);
      chk("gray",   32'(RQ_PTR_GRAY),    32'd0);
      chk("level",  32'(R_LEVEL),        32'd0);
      chk("empty",  32'(R_EMPTY),        32'd1);
      chk("aempty", 32'(R_ALMOST_EMPTY), 32'd1);
      chk("pop",    32'(R_POP),          32'd0);
      @(negedge R_CLK);
      R_RST = 1'b0;

      // Read while empty: ignored
      phase = "empty_read";
      for (int i = 0; i < 10; i++) cyc(1'b1, 4'd0, 1'b0, mk(0, 0, 0, 1, 1));

      // Write visibility through the two-stage synchronizer
      phase = "sync_latency";
      cyc(1'b0, 4'd1, 1'b0, mk(0, 0, 0, 1, 1));
      cyc(1'b0, 4'd1, 1'b0, mk(0, 0, 0, 1, 1));
      cyc(1'b0, 4'd1, 1'b0, mk(0, 0, 1, 0, 1));

      // Pop on the same edge the synced write pointer advances: level holds at 1
      phase = "simultaneous";
      cyc(1'b0, 4'd3, 1'b0, mk(0, 0, 1, 0, 1));
      cyc(1'b0, 4'd3, 1'b0, mk(0, 0, 1, 0, 1));
      cyc(1'b1, 4'd3, 1'b1, mk(1, 1, 1, 0, 1));
      cyc(1'b1, 4'd3, 1'b1, mk(2, 3, 0, 1, 1));
      cyc(1'b1, 4'd3, 1'b0, mk(2, 3, 0, 1, 1));

      // Make the FIFO non-empty, then reset between clock edges
      phase = "pre_reset";
      cyc(1'b0, 4'd2, 1'b0, mk(2, 3, 0, 1, 1));
      cyc(1'b0, 4'd2, 1'b0, mk(2, 3, 0, 1, 1));
      cyc(1'b0, 4'd2, 1'b0, mk(2, 3, 1, 0, 1));
      phase = "async_reset";
      #2;
      R_RST       = 1'b1;
      WQ_PTR_GRAY = 4'd0;
      RINC        = 1'b0;
      #1;
      chk("addr",   32'(R_ADDRESS),      32'd0);
      chk("gray",   32'(RQ_PTR_GRAY),    32'd0);
      chk("level",  32'(R_LEVEL),        32'd0);
      chk("empty",  32'(R_EMPTY),        32'd1);
      chk("aempty", 32'(R_ALMOST_EMPTY), 32'd1);
      #1;
      R_RST = 1'b0;
      @(negedge R_CLK);

      // Full drain of 8 entries, back-to-back, then an ignored extra read
      phase = "drain";
      cyc(1'b0, 4'b1100, 1'b0, mk(0, 0, 0, 1, 1));
      cyc(1'b0, 4'b1100, 1'b0, mk(0, 0, 0, 1, 1));
      cyc(1'b0, 4'b1100, 1'b0, mk(0, 0, 8, 0, 0));
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 4'b1100, 1'b1,
             mk((k + 1) % 8, gtab[k+1], 7 - k, (k == 7) ? 1 : 0, ((7 - k) <= 1) ? 1 : 0));
      end
      cyc(1'b1, 4'b1100, 1'b0, mk(0, 12, 0, 1, 1));

      // Wrap-around: write pointer to bin 12, pop 4
      phase = "wrap12";
      cyc(1'b0, 4'b1010, 1'b0, mk(0, 12, 0, 1, 1));
      cyc(1'b0, 4'b1010, 1'b0, mk(0, 12, 0, 1, 1));
      cyc(1'b0, 4'b1010, 1'b0, mk(0, 12, 4, 0, 0));
      for (int j = 0; j < 4; j++) begin
         cyc(1'b1, 4'b1010, 1'b1,
             mk(j + 1, wg1[j], 3 - j, (j == 3) ? 1 : 0, ((3 - j) <= 1) ? 1 : 0));
      end

      // Continue through bin 15 -> 0 (pointer wraps fully)
      phase = "wrap0";
      cyc(1'b0, 4'b0000, 1'b0, mk(4, 10, 0, 1, 1));
      cyc(1'b0, 4'b0000, 1'b0, mk(4, 10, 0, 1, 1));
      cyc(1'b0, 4'b0000, 1'b0, mk(4, 10, 4, 0, 0));
      for (int j = 0; j < 4; j++) begin
         cyc(1'b1, 4'b0000, 1'b1,
             mk(wa2[j], wg2[j], 3 - j, (j == 3) ? 1 : 0, ((3 - j) <= 1) ? 1 : 0));
      end
      cyc(1'b1, 4'b0000, 1'b0, mk(0, 0, 0, 1, 1));

      phase = "final";
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s/sb_leftover: observed %0d records expected 0", phase, exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the multi-clock asynchronous FIFO. It runs in the read clock domain and owns the read pointer, which it keeps in binary and Gray form. It synchronizes the Gray write pointer from the write domain, produces the read address for the FIFO memory, and generates the empty, almost-empty and fill-level status. It is the counterpart of the write-side memory/pointer logic, which receives `RQ_PTR_GRAY` from this block.

## Interface
- `ADDRESS_BITS`, 3, memory address width; pointers are `ADDRESS_BITS+1` bits.
- `FIFO_DEPTH`, 8, must equal 2^`ADDRESS_BITS`.
- `SYNC_STAGES`, 2, flop stages on the write-pointer synchronizer; minimum 2.
- `ALMOST_EMPTY_TH`, 1, `R_ALMOST_EMPTY` asserts when level <= this value.

- `R_CLK`  in  1  read-domain clock; one clock only.
- `R_RST`  in  1  asynchronous, active-high reset.
- `RINC`  in  1  read request; a pop happens when `RINC & ~R_EMPTY`.
- `WQ_PTR_GRAY`  in  ADDRESS_BITS+1  Gray write pointer from the write domain, unsynchronized.
- `R_ADDRESS`  out  ADDRESS_BITS  head address into the FIFO memory.
- `RQ_PTR_GRAY`  out  ADDRESS_BITS+1  registered Gray read pointer, sent to the write domain.
- `R_EMPTY`  out  1  registered empty flag.
- `R_ALMOST_EMPTY`  out  1  registered almost-empty flag.
- `R_LEVEL`  out  ADDRESS_BITS+1  registered entry count, range 0..`FIFO_DEPTH`.
- `R_POP`  out  1  combinational `RINC & ~R_EMPTY`; marks a pop accepted this cycle.

## Operation
- Pointer update:
  - `rbin_next = rbin + R_POP`, modulo 2^(ADDRESS_BITS+1).
  - `rgray_next = rbin_next ^ (rbin_next >> 1)`.
  - `rbin` and `RQ_PTR_GRAY` register `rbin_next` and `rgray_next` each edge.
- `R_ADDRESS = rbin[ADDRESS_BITS-1:0]`, driven directly from the register with no added logic.
- Synchronizer:
  - `WQ_PTR_GRAY` passes through `SYNC_STAGES` flops to give `wq_sync_gray`.
  - `wq_sync_bin = gray2bin(wq_sync_gray)`.
  - Only Gray values cross the clock boundary.
- Empty: `R_EMPTY <= (rgray_next == wq_sync_gray)`.
- Level: `R_LEVEL <= wq_sync_bin - rbin_next`, modulo 2^(ADDRESS_BITS+1).
- Almost-empty: `R_ALMOST_EMPTY <= (wq_sync_bin - rbin_next) <= ALMOST_EMPTY_TH`.
- Empty read: `RINC` while `R_EMPTY=1` is ignored; no pointer change and `R_POP=0`.
- Wrap-around: the extra pointer MSB toggles every `FIFO_DEPTH` pops. Empty means all bits are equal.
- Pop on the last entry: `R_EMPTY` asserts on the same edge that consumes that entry. There is no over-read.
- Pop coinciding with a write:
  - Status uses only the synchronized pointer, so it is pessimistic. A new write is never visible before the sync latency, and the flags never show data that is not there.
  - Level stays unchanged if the synced pointer advances on the same edge as a pop.
- Reset mid-operation:
  - All registers clear immediately, without a clock edge.
  - Pointers return to 0, and any entries in flight are discarded.
  - The write domain must be reset in the same system reset event.

## Timing
- Reset values:
  - `R_ADDRESS=0`, `RQ_PTR_GRAY=0`, `R_LEVEL=0`.
  - `R_EMPTY=1`, `R_ALMOST_EMPTY=1`.
  - All synchronizer flops 0.
  - `R_POP=0`, because `R_EMPTY=1`.
- Pop latency: with `RINC=1` and `R_EMPTY=0` at edge E, all of the following update after E: `R_ADDRESS`, `RQ_PTR_GRAY`, `R_LEVEL`, `R_EMPTY`, `R_ALMOST_EMPTY`.
- Write visibility: if `WQ_PTR_GRAY` changes and is stable before edge E0, then with `SYNC_STAGES=2`:
  - stage 1 captures at E0;
  - stage 2 captures at E1;
  - `R_EMPTY`, `R_LEVEL` and `R_ALMOST_EMPTY` reflect the write after E2.
  - In general the flags reflect the write after E(`SYNC_STAGES`).
- Back-to-back pops: one per cycle, sustained, with no bubbles while `R_EMPTY=0`.

## Structure
- Shared package `fifo_pkg` holds:
  - default `ADDRESS_BITS` and `FIFO_DEPTH`;
  - the pointer-width constant;
  - `bin2gray` and `gray2bin` functions, reused by the write-side controller.
- Sub-module `bus_sync`:
  - parameterized width and stage count;
  - reset to 0 on `R_RST`;
  - also reused by the write side for `RQ_PTR_GRAY`.

## Test plan
- Async reset, with `R_RST` pulsed mid-cycle while the FIFO is non-empty -> `R_EMPTY=1`, `R_LEVEL=0`, `R_ADDRESS=0`, `RQ_PTR_GRAY=0`, all before the next `R_CLK` edge.
- Read when empty: `WQ_PTR_GRAY=0`, `RINC=1` for 10 cycles -> `R_POP=0` throughout, `R_ADDRESS=0`, `R_LEVEL=0`.
- Sync latency: `WQ_PTR_GRAY` 0->1 before E0 -> `R_EMPTY=1` through E1, then 0 after E2; `R_LEVEL=1`, `R_ALMOST_EMPTY=1`.
- Full drain: `WQ_PTR_GRAY=4'b1100` (bin 8), `RINC=1` continuously ->
  - `R_ADDRESS` steps 0..7;
  - `RQ_PTR_GRAY` steps 0,1,3,2,6,7,5,4,12;
  - `R_LEVEL` steps 8..0;
  - `R_EMPTY` rises on the 8th pop edge.
- Wrap-around: after the drain, `WQ_PTR_GRAY=4'b1010` (bin 12), then 4 pops -> `R_ADDRESS` 0..3, `RQ_PTR_GRAY=4'b1010`, `R_EMPTY=1`. Continue through bin 15->0 with no false full or empty.
- Simultaneous events: at level 1, pop on the same edge the synced pointer advances by 1 -> `R_POP=1`, `R_EMPTY` stays 0, `R_LEVEL` stays 1.
